// File: rtl/vscpu_div_pkg.sv
// rtl/vscpu_div_pkg.sv - register offsets, status bits and FSM states of the bus divider
package vscpu_div_pkg;

  localparam logic [2:0] OFF_DIVIDEND  = 3'd0;
  localparam logic [2:0] OFF_DIVISOR   = 3'd1;
  localparam logic [2:0] OFF_CTRL      = 3'd2;
  localparam logic [2:0] OFF_QUOTIENT  = 3'd3;
  localparam logic [2:0] OFF_REMAINDER = 3'd4;
  localparam int         NUM_REGS      = 5;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_DZ   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vscpu_div_core.sv
// rtl/vscpu_div_core.sv - multi-cycle restoring unsigned divider, one quotient bit per clock
module vscpu_div_core
  import vscpu_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic              dz,
  output logic              finish,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t            state, state_d;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] prem;
  logic [DATA_W-1:0] qsh;
  logic [DATA_W:0]   trial, diff;
  logic [DATA_W-1:0] prem_n;
  logic              qbit;
  logic              load, fin_run, fin_dz;

  // Shift the next dividend bit into the partial remainder; no borrow means it fits.
  always_comb begin
    trial  = {prem, qsh[DATA_W-1]};
    diff   = trial - {1'b0, divisor};
    qbit   = ~diff[DATA_W];
    prem_n = qbit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    fin_run = 1'b0;
    fin_dz  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            fin_dz  = 1'b1;
          end else begin
            state_d = RUN;
            load    = 1'b1;
          end
        end
      end
      RUN: begin
        if (count == CNT_W'(DATA_W - 1)) begin
          state_d = DONE;
          fin_run = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      prem      <= '0;
      qsh       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else begin
      state <= state_d;
      if (load) begin
        count <= '0;
        prem  <= '0;
        qsh   <= dividend;
        dz    <= 1'b0;
      end else if (state == RUN) begin
        count <= count + CNT_W'(1);
        prem  <= prem_n;
        qsh   <= {qsh[DATA_W-2:0], qbit};
      end
      if (fin_run) begin
        quotient  <= {qsh[DATA_W-2:0], qbit};
        remainder <= prem_n;
      end
      if (fin_dz) begin
        quotient  <= '1;
        remainder <= dividend;
        dz        <= 1'b1;
      end
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign finish = fin_run | fin_dz;

endmodule

// File: rtl/vscpu_div_periph.sv
// rtl/vscpu_div_periph.sv - memory-mapped divider on the VSCPU RAM bus, blram-style 1-cycle reads
// Define VSCPU_DIV_IRQ_EN to drive a one-cycle completion pulse on o_irq.
module vscpu_div_periph
  import vscpu_div_pkg::*;
#(
  parameter int              SIZE      = 14,
  parameter int              DATA_W    = 32,
  parameter logic [SIZE-1:0] BASE_ADDR = 14'h3FF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   i_addr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sel,
  output logic              o_ram_we,
  output logic              o_irq
);

`ifdef VSCPU_DIV_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic [SIZE-1:0]   offset;
  logic [2:0]        off;
  logic              hit, wr_en, start;
  logic [DATA_W-1:0] dividend, divisor, quotient, remainder, rd_data;
  logic              busy, done, dz, finish;

  // Unsigned offset from the base makes addresses below the window wrap high and miss.
  assign offset   = i_addr - BASE_ADDR;
  assign hit      = offset < SIZE'(NUM_REGS);
  assign off      = offset[2:0];
  assign wr_en    = i_we & hit;
  assign o_ram_we = i_we & ~hit;
  assign start    = wr_en && (off == OFF_CTRL) && i_data[0];

  vscpu_div_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .dz       (dz),
    .finish   (finish),
    .quotient (quotient),
    .remainder(remainder)
  );

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_DIVIDEND:  rd_data = dividend;
      OFF_DIVISOR:   rd_data = divisor;
      OFF_CTRL: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done;
        rd_data[STAT_DZ]   = dz;
      end
      OFF_QUOTIENT:  rd_data = quotient;
      OFF_REMAINDER: rd_data = remainder;
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend <= '0;
      divisor  <= '0;
      o_data   <= '0;
      o_sel    <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      // Operands are frozen while a divide is in flight.
      if (wr_en && !busy && off == OFF_DIVIDEND) dividend <= i_data;
      if (wr_en && !busy && off == OFF_DIVISOR)  divisor  <= i_data;
      o_sel  <= hit;
      o_data <= hit ? rd_data : '0;
      o_irq  <= finish & IRQ_EN;
    end
  end

endmodule

// File: tb/tb_vscpu_div_periph.sv
// tb/tb_vscpu_div_periph.sv - directed and random checks of the bus divider against arithmetic
module tb_vscpu_div_periph;

  localparam int          DATA_W = 32;
  localparam logic [13:0] BASE   = 14'h3FF0;
`ifdef VSCPU_DIV_IRQ_EN
  localparam int IRQ_PULSE = 1;
`else
  localparam int IRQ_PULSE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] i_addr;
  logic        i_we;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_sel;
  logic        o_ram_we;
  logic        o_irq;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;

  vscpu_div_periph dut (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (i_addr),
    .i_we    (i_we),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .o_ram_we(o_ram_we),
    .o_irq   (o_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_irq) irq_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    i_addr = BASE + 14'(off);
    i_we   = 1'b1;
    i_data = d;
    step();
    i_we   = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] off, output logic [31:0] d);
    i_addr = BASE + 14'(off);
    i_we   = 1'b0;
    step();
    d = o_data;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r, st, v;
    int busy_n, irq0;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    irq0 = irq_cnt;
    wr(3'd0, a);
    wr(3'd1, b);
    wr(3'd2, 32'd1);
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      rd_reg(3'd2, st);
      if (!st[0]) break;
      busy_n++;
    end
    check({tag, " busy_cycles"}, busy_n, (b == 32'd0) ? 32'd0 : DATA_W);
    check({tag, " status"}, st, (b == 32'd0) ? 32'h6 : 32'h2);
    rd_reg(3'd3, v);
    check({tag, " quotient"}, v, q);
    rd_reg(3'd4, v);
    check({tag, " remainder"}, v, r);
    check({tag, " irq_pulses"}, irq_cnt - irq0, IRQ_PULSE);
  endtask

  initial begin
    logic [31:0] v, a, b, st;
    int steps, irq0;

    rst = 1'b1; i_we = 1'b0; i_addr = '0; i_data = '0;
    repeat (3) step();
    rst = 1'b0;
    check("reset irq", {31'b0, o_irq}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      rd_reg(3'(k), v);
      check($sformatf("reset reg%0d", k), v, 32'd0);
      check($sformatf("reset sel%0d", k), {31'b0, o_sel}, 32'd1);
    end

    run_div("9/5", 32'd9, 32'd5);
    run_div("12/5", 32'd12, 32'd5);
    run_div("ffffffff/1", 32'hFFFF_FFFF, 32'd1);
    run_div("5/12", 32'd5, 32'd12);
    run_div("7/0", 32'd7, 32'd0);
    run_div("7/0 again", 32'd7, 32'd0);
    run_div("after dz", 32'd1000, 32'd7);
    run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = (a >> $urandom_range(0, 31)) | 32'd1;
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", n), a, b);
    end

    // Operand writes and restart during a divide are ignored.
    irq0 = irq_cnt;
    wr(3'd0, 32'd100);
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd1);
    steps = 0;
    repeat (9) begin rd_reg(3'd2, st); steps++; end
    wr(3'd0, 32'd50); steps++;
    wr(3'd1, 32'd7);  steps++;
    wr(3'd2, 32'd1);  steps++;
    for (int i = 0; i < 100; i++) begin
      rd_reg(3'd2, st);
      steps++;
      if (!st[0]) break;
    end
    check("ignore done_edge", steps, 32'd33);
    check("ignore status", st, 32'h2);
    rd_reg(3'd3, v); check("ignore quotient", v, 32'd33);
    rd_reg(3'd4, v); check("ignore remainder", v, 32'd1);
    rd_reg(3'd0, v); check("ignore dividend", v, 32'd100);
    rd_reg(3'd1, v); check("ignore divisor", v, 32'd3);
    check("ignore irq_pulses", irq_cnt - irq0, IRQ_PULSE);

    // Reset in the middle of a divide.
    wr(3'd0, 32'd1000);
    wr(3'd1, 32'd7);
    wr(3'd2, 32'd1);
    repeat (14) step();
    irq0 = irq_cnt;
    rst = 1'b1;
    i_addr = BASE + 14'd2;
    step();
    rst = 1'b0;
    check("midrst sel", {31'b0, o_sel}, 32'd0);
    check("midrst data", o_data, 32'd0);
    check("midrst irq", {31'b0, o_irq}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      rd_reg(3'(k), v);
      check($sformatf("midrst reg%0d", k), v, 32'd0);
    end
    repeat (40) step();
    check("midrst no_irq", irq_cnt - irq0, 32'd0);
    rd_reg(3'd2, v);
    check("midrst status_later", v, 32'd0);
    run_div("post-reset 12/5", 32'd12, 32'd5);

    // Read-only offsets ignore writes.
    wr(3'd3, 32'hDEAD_BEEF);
    wr(3'd4, 32'hDEAD_BEEF);
    rd_reg(3'd3, v); check("ro quotient", v, 32'd2);
    rd_reg(3'd4, v); check("ro remainder", v, 32'd2);

    // RAM write-enable gating and window edges.
    i_addr = 14'd150; i_we = 1'b1; i_data = 32'h1234;
    #1;
    check("ram150 we", {31'b0, o_ram_we}, 32'd1);
    step();
    check("ram150 sel", {31'b0, o_sel}, 32'd0);
    check("ram150 data", o_data, 32'd0);
    i_addr = BASE; i_data = 32'h55;
    #1;
    check("base we", {31'b0, o_ram_we}, 32'd0);
    step();
    check("base sel", {31'b0, o_sel}, 32'd1);
    i_addr = BASE + 14'd5;
    #1;
    check("base+5 we", {31'b0, o_ram_we}, 32'd1);
    step();
    check("base+5 sel", {31'b0, o_sel}, 32'd0);
    i_addr = BASE - 14'd1;
    #1;
    check("base-1 we", {31'b0, o_ram_we}, 32'd1);
    step();
    check("base-1 sel", {31'b0, o_sel}, 32'd0);
    i_we = 1'b0;
    rd_reg(3'd0, v);
    check("base store dividend", v, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
